trig_pueo_command_decoder: RTL

- Receive-side decoder for the 32-bit PUEO command word that the TURF trigger/command encoder broadcasts once per sysclk phase period.
- Sits on the SURF side, after the command deserializer, in the sysclk domain.
- Splits each word into:
  - a PPS pulse
  - a run-command strobe
  - a firmware-update (FWU) byte stream with mark events
  - a trigger stream, buffered in a small FIFO for downstream readout

---
 rtl/trig_pueo_cmd_pkg.sv | 48 ++++
 rtl/pueo_cmd_fifo.sv | 50 +++++
 rtl/trig_pueo_command_decoder.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/trig_pueo_cmd_pkg.sv
// Field layout and helpers for the 32-bit PUEO command word.
package trig_pueo_cmd_pkg;

  localparam int unsigned IDLE_BIT   = 31;
  localparam int unsigned PPS_BIT    = 30;
  localparam int unsigned RSVD_HI    = 29;
  localparam int unsigned RSVD_LO    = 28;
  localparam int unsigned RUNCMD_HI  = 27;
  localparam int unsigned RUNCMD_LO  = 26;
  localparam int unsigned M1TYPE_HI  = 25;
  localparam int unsigned M1TYPE_LO  = 24;
  localparam int unsigned M1DATA_HI  = 23;
  localparam int unsigned M1DATA_LO  = 16;
  localparam int unsigned TRIGV_BIT  = 15;
  localparam int unsigned TRIG_HI    = 14;
  localparam int unsigned TRIG_LO    = 0;
  // Whole message portion, checked for stray bits on idle words.
  localparam int unsigned MSG_HI     = 30;
  localparam int unsigned MSG_LO     = 16;

  localparam logic [1:0] RUNCMD_NOOP = 2'd0;

  typedef enum logic [1:0] {
    NOOP_MARK = 2'd0,
    RSVD1     = 2'd1,
    RSVD2     = 2'd2,
    FWU_DATA  = 2'd3
  } m1type_e;

  // Everything a single word can ask for in its decode cycle.
  typedef struct packed {
    logic        pps;
    logic        runcmd_valid;
    logic [1:0]  runcmd;
    logic        mark;
    logic        mark_buf;
    logic        fwu_push;
    logic [7:0]  fwu_data;
    logic        trig_push;
    logic [14:0] trig_data;
    logic        msg_err;
  } cmd_fields_t;

  function automatic logic [15:0] sat_inc(logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/pueo_cmd_fifo.sv
// Single-clock first-word-fall-through FIFO; pushes into a full FIFO are
// dropped and flagged on drop, unless a pop frees the slot in the same cycle.
module pueo_cmd_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             drop,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  input  logic             rd_ready
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Extra MSB distinguishes full from empty when the addresses match.
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             full, pop, push;

  always_comb begin
    rd_valid = (wr_ptr_q != rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop      = rd_valid && rd_ready;
    push     = wr_en && (!full || pop);
    drop     = wr_en && full && !pop;
    rd_data  = mem_q[rd_ptr_q[AW-1:0]];
  end

  // Pointer update; both wrap naturally modulo 2*DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // Storage write; contents need no reset since the pointers gate reads.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/trig_pueo_command_decoder.sv
// SURF-side decoder for the TURF command word: PPS, run command, FWU byte
// stream with marks, and a buffered trigger stream, plus error counters.
module trig_pueo_command_decoder
  import trig_pueo_cmd_pkg::*;
#(
  parameter int unsigned TRIG_FIFO_DEPTH = 16,
  parameter int unsigned FWU_FIFO_DEPTH  = 4,
  parameter string       SYSCLKTYPE      = "NONE"
) (
  input  logic        sysclk_i,
  input  logic        sysclk_rstn_i,
  input  logic        sysclk_phase_i,
  input  logic [31:0] command_i,
  output logic        pps_o,
  output logic        runcmd_valid_o,
  output logic [1:0]  runcmd_o,
  output logic        fwu_mark_o,
  output logic        fwu_mark_buf_o,
  output logic [7:0]  m_fwu_tdata,
  output logic        m_fwu_tvalid,
  input  logic        m_fwu_tready,
  output logic [14:0] m_trig_tdata,
  output logic        m_trig_tvalid,
  input  logic        m_trig_tready,
  output logic [15:0] trig_overflow_o,
  output logic [15:0] fwu_overflow_o,
  output logic [15:0] msg_err_o,
  input  logic        count_clr_i
);

  if (TRIG_FIFO_DEPTH < 4 || TRIG_FIFO_DEPTH > 64 ||
      (TRIG_FIFO_DEPTH & (TRIG_FIFO_DEPTH - 1)) != 0) begin : g_bad_trig_depth
    $error("TRIG_FIFO_DEPTH must be a power of 2 in 4..64");
  end
  if (FWU_FIFO_DEPTH < 2 || FWU_FIFO_DEPTH > 16 ||
      (FWU_FIFO_DEPTH & (FWU_FIFO_DEPTH - 1)) != 0) begin : g_bad_fwu_depth
    $error("FWU_FIFO_DEPTH must be a power of 2 in 2..16");
  end
  if (SYSCLKTYPE == "") begin : g_bad_clk_tag
    $error("SYSCLKTYPE must not be empty");
  end

  logic [31:0]  cmd_q;
  logic         cmd_valid_q;
  cmd_fields_t  fields;
  m1type_e      m1type;
  logic         rsvd_type;
  logic [1:0]   runcmd_q;
  logic         mark_buf_q;
  logic         trig_drop, fwu_drop;
  logic [15:0]  trig_ovf_q, fwu_ovf_q, msg_err_q;

  // Capture the word on its phase cycle; the next cycle is its decode cycle.
  always_ff @(posedge sysclk_i or negedge sysclk_rstn_i) begin
    if (!sysclk_rstn_i) begin
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
    end else begin
      cmd_valid_q <= sysclk_phase_i;
      if (sysclk_phase_i) cmd_q <= command_i;
    end
  end

  // Decode the registered word into its individual actions.
  always_comb begin
    fields    = '0;
    m1type    = m1type_e'(cmd_q[M1TYPE_HI:M1TYPE_LO]);
    rsvd_type = 1'b0;
    if (cmd_valid_q) begin
      fields.trig_push = cmd_q[TRIGV_BIT];
      fields.trig_data = cmd_q[TRIG_HI:TRIG_LO];
      if (cmd_q[IDLE_BIT]) begin
        fields.msg_err = |cmd_q[MSG_HI:MSG_LO];
      end else begin
        fields.pps          = cmd_q[PPS_BIT];
        fields.runcmd       = cmd_q[RUNCMD_HI:RUNCMD_LO];
        fields.runcmd_valid = (cmd_q[RUNCMD_HI:RUNCMD_LO] != RUNCMD_NOOP);
        fields.fwu_data     = cmd_q[M1DATA_HI:M1DATA_LO];
        case (m1type)
          FWU_DATA:  fields.fwu_push = 1'b1;
          NOOP_MARK: begin
            fields.mark     = cmd_q[M1DATA_LO + 1];
            fields.mark_buf = cmd_q[M1DATA_LO];
          end
          default:   rsvd_type = 1'b1;
        endcase
        // At most one error per word, whatever the combination of faults.
        fields.msg_err = rsvd_type || (|cmd_q[RSVD_HI:RSVD_LO]) ||
                         !(fields.pps || fields.runcmd_valid || fields.fwu_push || fields.mark);
      end
    end
  end

  // Hold the last run command and mark buffer between strobes.
  always_ff @(posedge sysclk_i or negedge sysclk_rstn_i) begin
    if (!sysclk_rstn_i) begin
      runcmd_q   <= RUNCMD_NOOP;
      mark_buf_q <= 1'b0;
    end else begin
      if (fields.runcmd_valid) runcmd_q   <= fields.runcmd;
      if (fields.mark)         mark_buf_q <= fields.mark_buf;
    end
  end

  // Saturating event counters; clear wins over a same-cycle increment.
  always_ff @(posedge sysclk_i or negedge sysclk_rstn_i) begin
    if (!sysclk_rstn_i) begin
      trig_ovf_q <= '0;
      fwu_ovf_q  <= '0;
      msg_err_q  <= '0;
    end else if (count_clr_i) begin
      trig_ovf_q <= '0;
      fwu_ovf_q  <= '0;
      msg_err_q  <= '0;
    end else begin
      if (trig_drop)      trig_ovf_q <= sat_inc(trig_ovf_q);
      if (fwu_drop)       fwu_ovf_q  <= sat_inc(fwu_ovf_q);
      if (fields.msg_err) msg_err_q  <= sat_inc(msg_err_q);
    end
  end

  pueo_cmd_fifo #(
    .WIDTH (15),
    .DEPTH (TRIG_FIFO_DEPTH)
  ) u_trig_fifo (
    .clk      (sysclk_i),
    .rst_n    (sysclk_rstn_i),
    .wr_en    (fields.trig_push),
    .wr_data  (fields.trig_data),
    .drop     (trig_drop),
    .rd_data  (m_trig_tdata),
    .rd_valid (m_trig_tvalid),
    .rd_ready (m_trig_tready)
  );

  pueo_cmd_fifo #(
    .WIDTH (8),
    .DEPTH (FWU_FIFO_DEPTH)
  ) u_fwu_fifo (
    .clk      (sysclk_i),
    .rst_n    (sysclk_rstn_i),
    .wr_en    (fields.fwu_push),
    .wr_data  (fields.fwu_data),
    .drop     (fwu_drop),
    .rd_data  (m_fwu_tdata),
    .rd_valid (m_fwu_tvalid),
    .rd_ready (m_fwu_tready)
  );

  // New run command / mark buffer show up in the same cycle as their strobe.
  always_comb begin
    pps_o           = fields.pps;
    runcmd_valid_o  = fields.runcmd_valid;
    runcmd_o        = fields.runcmd_valid ? fields.runcmd : runcmd_q;
    fwu_mark_o      = fields.mark;
    fwu_mark_buf_o  = fields.mark ? fields.mark_buf : mark_buf_q;
    trig_overflow_o = trig_ovf_q;
    fwu_overflow_o  = fwu_ovf_q;
    msg_err_o       = msg_err_q;
  end

endmodule
